alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the MIPS datapath. Registered single-cycle ops (AND/OR/NOR/add/sub/slt/sltu)
//  plus iterative unsigned multiply (and optional divide) writing a HI/LO pair. Sits between the register
//  file and writeback; the control unit stalls on inReady low.
// PARAMETERS
//  WIDTH  32  operand/result width (>=4, even)
//  CNTW   $clog2(WIDTH)+1  iteration counter width (derived, localparam)
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  reset      in   1      synchronous, active-high
//  inValid    in   1      operation request this cycle
//  inReady    out  1      block can accept a request (1 = IDLE)
//  control    in   4      opcode, codes below
//  inputA     in   WIDTH  operand A / dividend / multiplicand
//  inputB     in   WIDTH  operand B / divisor / multiplier
//  outValid   out  1      one-cycle pulse: aluResult/resultHi/zero valid
//  aluResult  out  WIDTH  result (LO for MULTU/DIVU)
//  resultHi   out  WIDTH  HI: upper product / remainder; 0 for single-cycle ops
//  zero       out  1      aluResult == 0, registered with aluResult
// BEHAVIOUR
//  Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1100 NOR,
//   0011 MULTU, 1010 DIVU. Any other code: result 0, zero=1, outValid pulses after 1 cycle (no hang).
//  Accept: request taken when inValid && inReady; operands/control captured that edge.
//  inValid while inReady low is ignored (not queued); requester must hold until accepted.
//  FSM: IDLE -> (single-cycle op) DONE; IDLE -> (MULTU/DIVU) BUSY; BUSY -> DONE when count==WIDTH-1;
//   DONE -> IDLE. outValid=1 only in DONE; inReady=1 only in IDLE (no back-to-back accept in DONE).
//  Latency accept->outValid: single-cycle ops 1 cycle; MULTU/DIVU WIDTH+1 cycles.
//  ADD/SUB: modulo 2^WIDTH, carry/overflow discarded. SLT/SLTU: result {WIDTH-1 zeros, bit}.
//  MULTU: radix-2 shift-add, one multiplier bit per cycle LSB first, 2*WIDTH product; {resultHi,aluResult}=A*B.
//  DIVU: restoring, one quotient bit per cycle MSB first; aluResult=A/B, resultHi=A%B.
//   B==0: aluResult all ones, resultHi=A (no trap).
//  Outputs hold last result until next DONE; only outValid is pulsed.
//  Reset (any state, incl. mid-BUSY): state IDLE, counter 0, aluResult=0, resultHi=0, zero=1, outValid=0,
//   inReady=1 the cycle after reset deasserts; in-flight op discarded, no outValid.
//  reset and inValid same edge: reset wins, request dropped.
// CONFIGURATION
//  ALU_DIV_EN defined: DIVU datapath and remainder register built as above.
//  ALU_DIV_EN undefined: 1010 treated as unsupported code (1-cycle, result 0, zero=1); no divider logic.
// STRUCTURE
//  Package alu_pkg: opcode localparams (ALU_AND..ALU_DIVU), FSM state encoding (S_IDLE,S_BUSY,S_DONE).
//  One sub-module: alu_mc_iter - shared HI/LO shift register + adder/subtractor + counter for MULTU/DIVU;
//   top holds FSM, handshake, single-cycle logic and output registers.
// TESTING
//  ADD 0x7FFFFFFF+1 -> 0x80000000, zero=0, outValid 1 cycle after accept; SUB 5-5 -> 0, zero=1.
//  SLT A=0xFFFFFFFF,B=1 -> 1; SLTU same operands -> 0; NOR 0,0 -> 0xFFFFFFFF.
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001 after 33 cycles; inValid during BUSY ignored.
//  DIVU 100/7 -> lo 14, hi 2; DIVU 9/0 -> lo 0xFFFFFFFF, hi 9 (ALU_DIV_EN); without macro -> 1-cycle, lo 0, zero=1.
//  Reset asserted mid-MULTU (cycle 10) -> no outValid, inReady=1, aluResult=0 next cycle; new ADD then completes normally.
//  WIDTH=8 build: MULTU 0xFF*0x02 -> hi 0x01, lo 0xFE after 9 cycles; code 1111 -> result 0, no hang.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcodes and FSM state encoding shared by alu_mc and alu_mc_iter
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_MULTU = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1010;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mc_iter.sv
`default_nettype none
// ============================================================================
// alu_mc_iter : shared HI/LO shift register, adder/subtractor and counter for
//               MULTU (shift-add) and, with ALU_DIV_EN, DIVU (restoring)
// Revision: 1.0
// ============================================================================
module alu_mc_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             last
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic [CNTW-1:0]  count;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
  logic             div_mode;
  logic [WIDTH:0]   shifted;
  logic             qbit;
`endif

  // LO starts as the multiplier (or dividend); each step consumes one of its bits.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    hi_next = mul_sum[WIDTH:1];
    lo_next = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    shifted = {hi, lo[WIDTH-1]};
    qbit    = (shifted >= {1'b0, opnd});
    if (div_mode) begin
      hi_next = qbit ? WIDTH'(shifted - {1'b0, opnd}) : shifted[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], qbit};
    end
`endif
  end

  assign last = (count == CNTW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      count <= '0;
`ifdef ALU_DIV_EN
      div_mode <= 1'b0;
`endif
    end else if (load) begin
      hi    <= '0;
      count <= '0;
`ifdef ALU_DIV_EN
      div_mode <= is_div;
      lo       <= is_div ? a : b;
      opnd     <= is_div ? b : a;
`else
      lo    <= b;
      opnd  <= a;
`endif
    end else if (step) begin
      hi    <= hi_next;
      lo    <= lo_next;
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// alu_mc : multi-cycle MIPS ALU, registered single-cycle ops plus iterative
//          MULTU and optional DIVU (enabled by defining ALU_DIV_EN)
// Revision: 1.0
// ============================================================================
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             outValid,
  output logic [WIDTH-1:0] aluResult,
  output logic [WIDTH-1:0] resultHi,
  output logic             zero
);

  state_t           state;
  logic [WIDTH-1:0] sc_result;
  logic             is_iter;
  logic             iter_load;
  logic             iter_last;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // Unlisted codes (and DIVU without the divider) fall through to a zero result.
  always_comb begin
    sc_result = '0;
    case (control)
      ALU_AND:  sc_result = inputA & inputB;
      ALU_OR:   sc_result = inputA | inputB;
      ALU_ADD:  sc_result = inputA + inputB;
      ALU_SUB:  sc_result = inputA - inputB;
      ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
      ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
      ALU_NOR:  sc_result = ~(inputA | inputB);
      default:  sc_result = '0;
    endcase
  end

`ifdef ALU_DIV_EN
  assign is_iter = (control == ALU_MULTU) || (control == ALU_DIVU);
`else
  assign is_iter = (control == ALU_MULTU);
`endif

  assign iter_load = (state == S_IDLE) && inValid && is_iter;

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (iter_load),
    .step    (state == S_BUSY),
`ifdef ALU_DIV_EN
    .is_div  (control == ALU_DIVU),
`endif
    .a       (inputA),
    .b       (inputB),
    .hi_next (hi_next),
    .lo_next (lo_next),
    .last    (iter_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      inReady   <= 1'b1;
      outValid  <= 1'b0;
      aluResult <= '0;
      resultHi  <= '0;
      zero      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          outValid <= 1'b0;
          if (inValid) begin
            inReady <= 1'b0;
            if (is_iter) begin
              state <= S_BUSY;
            end else begin
              state     <= S_DONE;
              outValid  <= 1'b1;
              aluResult <= sc_result;
              resultHi  <= '0;
              zero      <= (sc_result == '0);
            end
          end
        end
        S_BUSY: begin
          // Capture the final iteration's combinational result on the way out.
          if (iter_last) begin
            state     <= S_DONE;
            outValid  <= 1'b1;
            aluResult <= lo_next;
            resultHi  <= hi_next;
            zero      <= (lo_next == '0);
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          outValid <= 1'b0;
          inReady  <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          outValid <= 1'b0;
          inReady  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
